// File: rtl/keypad_time_entry_if.sv
// keypad_time_entry_if: keypad lines and time-entry results between host and entry block
// master: drives en/mode/row, observes col, digits, digit_cnt, valid, commit, err
// slave : the entry block side
interface keypad_time_entry_if;
  logic       en;
  logic       mode;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] d5, d4, d3, d2, d1, d0;
  logic [2:0] digit_cnt;
  logic       valid;
  logic       commit;
  logic       err;
  modport master (output en, mode, row, input col, d5, d4, d3, d2, d1, d0, digit_cnt, valid, commit, err);
  modport slave  (input en, mode, row, output col, d5, d4, d3, d2, d1, d0, digit_cnt, valid, commit, err);
endinterface

// File: rtl/keypad_time_entry.sv
// keypad_time_entry: 4x4 keypad scanner with debounce feeding an MM:SS / HH:MM:SS BCD entry buffer
// clk: rising-edge clock; rst: async active-low reset
// kp : en, mode, row in; col, d5..d0, digit_cnt, valid, commit, err out
module keypad_time_entry #(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_SCANS = 4
) (
  input logic           clk,
  input logic           rst,
  keypad_time_entry_if.slave kp
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_SCANS + 1);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [1:0]      cidx_q, cidx_d, hits_q, hits_d;
  logic [3:0]      code_q, code_d, key_q, key_d;
  logic [CW-1:0]   deb_q, deb_d;
  logic [5:0][3:0] dig_q, dig_d;
  logic [2:0]      cnt_q, cnt_d, nlow, sum;
  logic            en_q, mode_q, arm_q, arm_d, commit_q, commit_d, err_q, err_d;
  logic            active, tick, done, scan_one, scan_none, ev, clr, valid;
  logic            is_digit, is_star, is_hash;
  logic [1:0]      rlow, kr, kc;
  logic [3:0]      this_code, scan_code, val;
  assign active    = kp.en & en_q;
  assign tick      = active && div_q == DW'(SCAN_DIV - 1);
  assign done      = tick && cidx_q == 2'd3;
  assign nlow      = {2'b0, ~kp.row[0]} + {2'b0, ~kp.row[1]} + {2'b0, ~kp.row[2]} + {2'b0, ~kp.row[3]};
  assign sum       = {1'b0, hits_q} + nlow;
  assign rlow      = !kp.row[0] ? 2'd0 : !kp.row[1] ? 2'd1 : !kp.row[2] ? 2'd2 : 2'd3;
  assign this_code = {rlow, cidx_q};
  assign scan_code = nlow != 3'd0 ? this_code : code_q;
  assign scan_one  = done && sum == 3'd1;
  assign scan_none = done && sum == 3'd0;
  assign kr        = key_d[3:2];
  assign kc        = key_d[1:0];
  assign is_digit  = kc != 2'd3 && (kr != 2'd3 || kc == 2'd1);
  assign is_star   = kr == 2'd3 && kc == 2'd0;
  assign is_hash   = kr == 2'd3 && kc == 2'd2;
  assign val       = kr == 2'd3 ? 4'd0 : {2'b0, kr} * 4'd3 + {2'b0, kc} + 4'd1;
  assign clr       = kp.mode != mode_q || (kp.en && !en_q);
  assign valid     = dig_q[3] <= 4'd5 && dig_q[1] <= 4'd5 &&
                     (kp.mode ? dig_q[5] < 4'd2 || (dig_q[5] == 4'd2 && dig_q[4] <= 4'd3)
                              : dig_q[5] == 4'd0 && dig_q[4] == 4'd0);
  always_comb begin
    div_d  = !active || tick ? '0 : div_q + 1'b1;
    cidx_d = !active ? 2'd0 : tick ? cidx_q + 2'd1 : cidx_q;
    hits_d = !active || done ? 2'd0 : tick ? (sum > 3'd2 ? 2'd2 : sum[1:0]) : hits_q;
    code_d = tick && nlow != 3'd0 ? this_code : code_q;
    // a press still held through reset must be released before it can register
    arm_d  = arm_q | scan_none;
    state_d = state_q;
    deb_d   = deb_q;
    key_d   = key_q;
    ev      = 1'b0;
    if (!active)
      state_d = IDLE;
    else if (done)
      case (state_q)
        IDLE: if (scan_one && arm_q) begin
          key_d   = scan_code;
          deb_d   = CW'(1);
          ev      = DEB_SCANS <= 1;
          state_d = DEB_SCANS <= 1 ? HELD : PRESS_WAIT;
        end
        PRESS_WAIT: if (scan_one && scan_code == key_q) begin
          deb_d   = deb_q + 1'b1;
          ev      = deb_d == CW'(DEB_SCANS);
          state_d = ev ? HELD : PRESS_WAIT;
        end else
          state_d = IDLE;
        HELD: if (scan_none) begin
          deb_d   = CW'(1);
          state_d = DEB_SCANS <= 1 ? IDLE : RELEASE_WAIT;
        end
        default: if (scan_none) begin
          deb_d   = deb_q + 1'b1;
          state_d = deb_d == CW'(DEB_SCANS) ? IDLE : RELEASE_WAIT;
        end else
          state_d = HELD;
      endcase
    dig_d = dig_q;
    cnt_d = cnt_q;
    if (clr || (ev && is_star)) begin
      dig_d = '0;
      cnt_d = 3'd0;
    end else if (ev && is_digit) begin
      dig_d = kp.mode ? {dig_q[4:0], val} : {8'h0, dig_q[2:0], val};
      cnt_d = cnt_q == (kp.mode ? 3'd6 : 3'd4) ? cnt_q : cnt_q + 3'd1;
    end else if (ev && !kp.mode)
      dig_d[5:4] = '0;
    commit_d = ev && is_hash && !clr && valid;
    err_d    = ev && is_hash && !clr && !valid;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      cidx_q   <= 2'd0;
      hits_q   <= 2'd0;
      code_q   <= 4'd0;
      key_q    <= 4'd0;
      deb_q    <= '0;
      dig_q    <= '0;
      cnt_q    <= 3'd0;
      en_q     <= 1'b0;
      mode_q   <= 1'b0;
      arm_q    <= 1'b0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cidx_q   <= cidx_d;
      hits_q   <= hits_d;
      code_q   <= code_d;
      key_q    <= key_d;
      deb_q    <= deb_d;
      dig_q    <= dig_d;
      cnt_q    <= cnt_d;
      en_q     <= kp.en;
      mode_q   <= kp.mode;
      arm_q    <= arm_d;
      commit_q <= commit_d;
      err_q    <= err_d;
    end
  assign kp.col       = en_q ? ~(4'b0001 << cidx_q) : 4'hF;
  assign kp.d5        = dig_q[5];
  assign kp.d4        = dig_q[4];
  assign kp.d3        = dig_q[3];
  assign kp.d2        = dig_q[2];
  assign kp.d1        = dig_q[1];
  assign kp.d0        = dig_q[0];
  assign kp.digit_cnt = cnt_q;
  assign kp.valid     = valid;
  assign kp.commit    = commit_q;
  assign kp.err       = err_q;
endmodule

// File: tb/tb_keypad_time_entry.sv
// tb_keypad_time_entry: directed checks of scanning, debounce and time entry with SCAN_DIV=4, DEB_SCANS=2
module tb_keypad_time_entry;
  logic clk = 1'b0;
  logic rst;
  logic ka_on, kb_on;
  logic [3:0] ka, kb, r;
  int checks = 0, errors = 0, ccnt = 0, ecnt = 0, both = 0, c0, e0;
  keypad_time_entry_if dif ();
  keypad_time_entry #(.SCAN_DIV(4), .DEB_SCANS(2)) dut (.clk(clk), .rst(rst), .kp(dif));
  always #5 clk = ~clk;
  always_comb begin
    r = 4'hF;
    if (ka_on && !dif.col[ka[1:0]]) r[ka[3:2]] = 1'b0;
    if (kb_on && !dif.col[kb[1:0]]) r[kb[3:2]] = 1'b0;
  end
  assign dif.row = r;
  always @(negedge clk) begin
    if (dif.commit) ccnt++;
    if (dif.err) ecnt++;
    if (dif.commit && dif.err) both++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [3:0] k);
    ka = k; ka_on = 1'b1;
    cyc(48);
    ka_on = 1'b0;
    cyc(48);
  endtask
  function automatic logic [23:0] digs();
    return {dif.d5, dif.d4, dif.d3, dif.d2, dif.d1, dif.d0};
  endfunction
  initial begin
    rst = 1'b0; dif.en = 1'b0; dif.mode = 1'b1;
    ka = 4'd0; kb = 4'd0; ka_on = 1'b0; kb_on = 1'b0;
    cyc(2);
    check("reset_col", dif.col, 4'hF);
    check("reset_digits", digs(), 24'h0);
    check("reset_cnt", dif.digit_cnt, 3'd0);
    check("reset_pulses", {dif.commit, dif.err}, 2'b00);
    check("reset_valid", dif.valid, 1'b1);
    rst = 1'b1;
    cyc(1);
    check("idle_col", dif.col, 4'hF);
    dif.en = 1'b1;
    cyc(1);
    check("scan_col0", dif.col, 4'b1110);
    cyc(4);
    check("scan_col1", dif.col, 4'b1101);
    cyc(4);
    check("scan_col2", dif.col, 4'b1011);
    cyc(4);
    check("scan_col3", dif.col, 4'b0111);
    cyc(4);
    check("scan_wrap", dif.col, 4'b1110);
    cyc(32);
    press(4'd0); press(4'd1); press(4'd2); press(4'd4); press(4'd5); press(4'd6);
    check("m1_digits", digs(), 24'h123456);
    check("m1_cnt", dif.digit_cnt, 3'd6);
    check("m1_valid", dif.valid, 1'b1);
    c0 = ccnt; e0 = ecnt;
    press(4'd14);
    check("m1_commit", ccnt - c0, 1);
    check("m1_commit_noerr", ecnt - e0, 0);
    check("m1_commit_hold", digs(), 24'h123456);
    press(4'd12);
    press(4'd1); press(4'd4); press(4'd13); press(4'd13); press(4'd13); press(4'd13);
    check("m1_240000", digs(), 24'h240000);
    check("m1_invalid", dif.valid, 1'b0);
    c0 = ccnt; e0 = ecnt;
    press(4'd14);
    check("m1_err", ecnt - e0, 1);
    check("m1_err_nocommit", ccnt - c0, 0);
    check("m1_err_hold", digs(), 24'h240000);
    press(4'd12);
    check("m1_star", digs(), 24'h0);
    check("m1_star_cnt", dif.digit_cnt, 3'd0);
    check("m1_star_valid", dif.valid, 1'b1);
    press(4'd10);
    check("m1_nine", digs(), 24'h000009);
    dif.mode = 1'b0;
    cyc(1);
    check("mode_clear", {digs(), dif.digit_cnt}, 27'h0);
    press(4'd0); press(4'd1); press(4'd2); press(4'd4); press(4'd5);
    check("m0_digits", digs(), 24'h002345);
    check("m0_cnt", dif.digit_cnt, 3'd4);
    check("m0_valid", dif.valid, 1'b1);
    press(4'd6); press(4'd13);
    check("m0_4560", digs(), 24'h004560);
    check("m0_invalid", dif.valid, 1'b0);
    press(4'd12);
    ka = 4'd8;
    repeat (3) begin
      ka_on = 1'b1; cyc(16);
      ka_on = 1'b0; cyc(16);
    end
    ka_on = 1'b1; cyc(64);
    ka_on = 1'b0; cyc(48);
    check("bounce_cnt", dif.digit_cnt, 3'd1);
    check("bounce_d0", digs(), 24'h000007);
    ka = 4'd0; kb = 4'd5; ka_on = 1'b1; kb_on = 1'b1;
    cyc(64);
    ka_on = 1'b0; kb_on = 1'b0;
    cyc(48);
    check("multi_cnt", dif.digit_cnt, 3'd1);
    check("multi_digits", digs(), 24'h000007);
    dif.en = 1'b0;
    cyc(2);
    check("dis_col", dif.col, 4'hF);
    press(4'd10);
    check("dis_hold", {digs(), dif.digit_cnt}, {24'h000007, 3'd1});
    dif.en = 1'b1;
    cyc(1);
    check("en_clear", {digs(), dif.digit_cnt}, 27'h0);
    ka = 4'd9; ka_on = 1'b1;
    cyc(64);
    check("hold8_cnt", dif.digit_cnt, 3'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_async", {digs(), dif.digit_cnt, dif.col}, {27'h0, 4'hF});
    cyc(1);
    rst = 1'b1;
    cyc(80);
    check("rst_noevent", dif.digit_cnt, 3'd0);
    ka_on = 1'b0;
    cyc(48);
    press(4'd9);
    check("repress_cnt", dif.digit_cnt, 3'd1);
    check("repress_d0", digs(), 24'h000008);
    check("never_both", both, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_time_entry.md
KEYPAD_TIME_ENTRY -- requirements
Module: keypad_time_entry

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles each column is driven (dwell).
REQ-002 Parameter DEB_SCANS, default 4, consecutive full scans a key state must persist to be accepted.
REQ-003 clk  input  1  system clock; every register is clocked on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 en  input  1  1 = entry active; 0 = idle.
REQ-006 mode  input  1  0 = 4-digit MM:SS entry; 1 = 6-digit HH:MM:SS entry.
REQ-007 row  input  4  keypad rows, active-low, row[0] = top row.
REQ-008 col  output  4  keypad column drive, active-low one-hot, col[0] = left column.
REQ-009 d5,d4,d3,d2,d1,d0  output  4 each  BCD entry buffer; d5 is the most significant digit.
REQ-010 digit_cnt  output  3  digits entered since last clear, saturating at the active width.
REQ-011 valid  output  1  buffer holds an in-range time for the current mode.
REQ-012 commit  output  1  one-cycle pulse: accepted entry.
REQ-013 err  output  1  one-cycle pulse: commit attempted on an invalid buffer.

Function
REQ-014 Key map (row,col): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D; A-D SHALL be ignored.
REQ-015 Scanner: with en=1, col SHALL cycle 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every SCAN_DIV cycles; one full scan = 4*SCAN_DIV cycles.
REQ-016 row SHALL be sampled on the last cycle of each column dwell; after col[3] is sampled, the scan result is "one key" (exactly one low row bit across all four columns), "none", or "multi".
REQ-017 Debounce FSM states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-018 IDLE -> PRESS_WAIT on a one-key scan; PRESS_WAIT -> HELD once the same key is seen DEB_SCANS consecutive scans, issuing exactly one key event; any other scan result returns PRESS_WAIT to IDLE.
REQ-019 HELD -> RELEASE_WAIT on a none scan; RELEASE_WAIT -> IDLE after DEB_SCANS consecutive none scans; any key scan returns RELEASE_WAIT to HELD; a held key SHALL NOT repeat.
REQ-020 Multi scans SHALL never produce an event (rollover rejected).
REQ-021 Digit event: active digits shift left one place (mode 1: d5..d0; mode 0: d3..d0); the new digit enters d0; the top active digit is discarded; digit_cnt increments and saturates at 4 or 6.
REQ-022 '*' event: d5..d0 = 0, digit_cnt = 0.
REQ-023 '#' event: if valid=1, commit pulses the cycle after the event and the buffer is held; if valid=0, err pulses instead and the buffer is unchanged.
REQ-024 valid is combinational on the buffer. Mode 1: d5d4 <= 23, d3 <= 5, d1 <= 5. Mode 0: d3 <= 5, d1 <= 5, d5 = d4 = 0. A digit_cnt of 0 is valid (time 00:00:00).
REQ-025 In mode 0, d5 and d4 SHALL be forced to 0 on every event.
REQ-026 A mode change SHALL clear the buffer and digit_cnt in the next cycle.
REQ-027 en=0: col = 1111, scan divider and FSM held in IDLE, buffer held, commit/err = 0.
REQ-028 The en 0->1 edge SHALL clear the buffer and digit_cnt and restart scanning at col[0] with a zeroed divider.
REQ-029 At most one event per scan; commit and err are never asserted together.

Reset
REQ-030 rst=0 SHALL asynchronously force: col = 1111; d5..d0 = 0; digit_cnt = 0; commit = err = 0; FSM = IDLE; divider = 0; column index = 0.
REQ-031 After rst returns to 1, scanning SHALL start on the first clk edge with en=1. Reset mid-press SHALL NOT generate an event for that press until it is released and pressed again.

Verification (SCAN_DIV=4, DEB_SCANS=2)
REQ-032 mode=1, keys 1,2,3,4,5,6 each held 3 scans then released 3 scans -> d5..d0 = 1,2,3,4,5,6; digit_cnt = 6; valid = 1; '#' -> single commit pulse.
REQ-033 mode=1, enter 2,4,0,0,0,0 then '#' -> valid = 0, err pulse, no commit; then '*' -> all digits 0, valid = 1.
REQ-034 mode=0, enter 1,2,3,4,5 -> d3..d0 = 2,3,4,5; d5 = d4 = 0; digit_cnt = 4.
REQ-035 Key '7' bouncing (alternating press/none each scan) for 6 scans, then held 4 scans -> exactly one event; d0 = 7.
REQ-036 Keys '1' and '5' pressed together -> no event. rst pulsed low mid-hold of '8' -> outputs 0 immediately; no event until '8' is released and pressed again.
